// File: rtl/pads_out_ctrl.sv
// Output pad controller: registered per-channel mode mux (core/force0/force1/blink)
// with a boot-gated safe state. Optional macro PADS_OUT_PAD_CELL_EN instantiates PDO24CDG pad cells.
module pads_out_ctrl #(
    parameter int unsigned        NUM_CH    = 9,
    parameter logic [NUM_CH-1:0]  SAFE_VAL  = '0,
    parameter int unsigned        BLINK_DIV = 4,
    parameter int unsigned        CNT_W     = 16,
    localparam int unsigned       CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_done,
    input  logic [NUM_CH-1:0] core_out,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    output logic              cfg_err,
    output logic              armed,
    output logic [NUM_CH-1:0] pad_out
);

    typedef enum logic [1:0] {
        MODE_CORE   = 2'b00,
        MODE_FORCE0 = 2'b01,
        MODE_FORCE1 = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_SAFE  = 1'b0,
        ST_ARMED = 1'b1
    } arm_e;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

    arm_e              arm_q, arm_d;
    mode_e             mode_q [NUM_CH];
    mode_e             mode_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic              cfg_err_q, cfg_err_d;
    logic [NUM_CH-1:0] out_q, out_d;
    logic              cfg_in_range;

    // Arming state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arm_q <= ST_SAFE;
        end else begin
            arm_q <= arm_d;
        end
    end

    // Arming next state: sticky once boot_done is seen
    always_comb begin
        arm_d = arm_q;
        if (arm_q == ST_SAFE && boot_done) begin
            arm_d = ST_ARMED;
        end
    end

    // Arming outputs
    always_comb begin
        armed = (arm_q == ST_ARMED);
    end

    assign cfg_in_range = ({1'b0, cfg_ch} < CH_LIMIT);

    // Matching per channel keeps out-of-range indices from ever addressing the mode array
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mode_d[i] = mode_q[i];
            if (cfg_we && cfg_ch == CH_W'(i)) begin
                mode_d[i] = mode_e'(cfg_mode);
            end
        end
        cfg_err_d = cfg_we && !cfg_in_range;
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (cnt_q == DIV_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        out_d = SAFE_VAL;
        if (armed) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                unique case (mode_q[i])
                    MODE_CORE:   out_d[i] = core_out[i];
                    MODE_FORCE0: out_d[i] = 1'b0;
                    MODE_FORCE1: out_d[i] = 1'b1;
                    MODE_BLINK:  out_d[i] = phase_q;
                    default:     out_d[i] = SAFE_VAL[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_CORE;
            end
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            out_q     <= SAFE_VAL;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= mode_d[i];
            end
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            cfg_err_q <= cfg_err_d;
            out_q     <= out_d;
        end
    end

    assign cfg_err = cfg_err_q;

`ifdef PADS_OUT_PAD_CELL_EN
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pad
        PDO24CDG u_pad (
            .I   (out_q[g]),
            .PAD (pad_out[g])
        );
    end
`else
    assign pad_out = out_q;
`endif

endmodule

// File: tb/tb_pads_out_ctrl.sv
// Directed self-checking bench for pads_out_ctrl (NUM_CH=9, SAFE_VAL=9'h0A5, BLINK_DIV=4).
module tb_pads_out_ctrl;

    localparam int unsigned NUM_CH = 9;
    localparam logic [8:0]  SAFE   = 9'h0A5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       boot_done;
    logic [8:0] core_out;
    logic       cfg_we;
    logic [3:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic       cfg_err;
    logic       armed;
    logic [8:0] pad_out;

    int checks = 0;
    int passed = 0;
    int edges  = 0;

    pads_out_ctrl #(
        .NUM_CH    (NUM_CH),
        .SAFE_VAL  (SAFE),
        .BLINK_DIV (4),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .boot_done (boot_done),
        .core_out  (core_out),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_err   (cfg_err),
        .armed     (armed),
        .pad_out   (pad_out)
    );

    always #5 clk = ~clk;

    // Blink level latched into the pads at edge n after the reset edge
    function automatic logic ph(input int n);
        return (((n - 1) / 4) % 2) == 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; boot_done = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_mode = 2'b00; core_out = '0;
        step();
        edges = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pad_out !== SAFE) $display("FAIL reset_pad: got %h expected %h", pad_out, SAFE); else passed++;
        checks++; if (armed !== 1'b0) $display("FAIL reset_armed: got %b expected 0", armed); else passed++;
        checks++; if (cfg_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", cfg_err); else passed++;
    endtask

    task automatic test_safe();
        // ch4=FORCE0 while unarmed: stored, not visible until arming
        cfg_we = 1'b1; cfg_ch = 4'd4; cfg_mode = 2'b01;
        for (int i = 0; i < 50; i++) begin
            core_out = 9'($urandom);
            step();
            cfg_we = 1'b0;
            checks++; if (pad_out !== SAFE) $display("FAIL safe_pad: got %h expected %h", pad_out, SAFE); else passed++;
            checks++; if (armed !== 1'b0) $display("FAIL safe_armed: got %b expected 0", armed); else passed++;
        end
    endtask

    task automatic test_arming();
        core_out = 9'h1FF; boot_done = 1'b1;
        step();
        boot_done = 1'b0;
        checks++; if (armed !== 1'b1) $display("FAIL arm_armed: got %b expected 1", armed); else passed++;
        checks++; if (pad_out !== SAFE) $display("FAIL arm_pad_T: got %h expected %h", pad_out, SAFE); else passed++;
        step();
        checks++; if (pad_out !== 9'h1EF) $display("FAIL arm_pad_T1: got %h expected 1ef", pad_out); else passed++;
        core_out = 9'h0F0;
        step();
        checks++; if (pad_out !== 9'h0E0) $display("FAIL arm_follow: got %h expected 0e0", pad_out); else passed++;
        checks++; if (armed !== 1'b1) $display("FAIL arm_sticky: got %b expected 1", armed); else passed++;
        cfg_we = 1'b1; cfg_ch = 4'd4; cfg_mode = 2'b00;
        step();
        cfg_we = 1'b0;
        checks++; if (pad_out !== 9'h0E0) $display("FAIL arm_wr_lat1: got %h expected 0e0", pad_out); else passed++;
        step();
        checks++; if (pad_out !== 9'h0F0) $display("FAIL arm_wr_lat2: got %h expected 0f0", pad_out); else passed++;
    endtask

    task automatic test_force();
        core_out = 9'h001;
        cfg_we = 1'b1; cfg_ch = 4'd3; cfg_mode = 2'b10;
        step();
        checks++; if (pad_out !== 9'h001) $display("FAIL force_w1: got %h expected 001", pad_out); else passed++;
        cfg_ch = 4'd0; cfg_mode = 2'b01;
        step();
        cfg_we = 1'b0;
        checks++; if (pad_out !== 9'h009) $display("FAIL force_ch3: got %h expected 009", pad_out); else passed++;
        checks++; if (cfg_err !== 1'b0) $display("FAIL force_noerr: got %b expected 0", cfg_err); else passed++;
        step();
        checks++; if (pad_out !== 9'h008) $display("FAIL force_ch0: got %h expected 008", pad_out); else passed++;
        core_out = 9'h1F6;
        step();
        checks++; if (pad_out !== 9'h1FE) $display("FAIL force_track: got %h expected 1fe", pad_out); else passed++;
    endtask

    task automatic test_blink();
        logic [8:0] exp;
        int highs = 0;
        core_out = 9'h000;
        cfg_we = 1'b1; cfg_ch = 4'd1; cfg_mode = 2'b11;
        step();
        cfg_ch = 4'd2;
        step();
        cfg_we = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            exp = 9'h008 | (ph(edges) ? 9'h006 : 9'h000);
            checks++; if (pad_out !== exp) $display("FAIL blink_vec: got %h expected %h", pad_out, exp); else passed++;
            checks++; if (pad_out[1] !== pad_out[2]) $display("FAIL blink_eq: got %b expected %b", pad_out[1], pad_out[2]); else passed++;
            highs += int'(pad_out[1]);
        end
        checks++; if (highs != 12) $display("FAIL blink_duty: got %0d expected 12", highs); else passed++;
        core_out = 9'h002;
        cfg_we = 1'b1; cfg_ch = 4'd1; cfg_mode = 2'b00;
        step();
        cfg_we = 1'b0;
        exp = 9'h008 | (ph(edges) ? 9'h006 : 9'h000);
        checks++; if (pad_out !== exp) $display("FAIL blink_core1: got %h expected %h", pad_out, exp); else passed++;
        step();
        exp = 9'h00A | (ph(edges) ? 9'h004 : 9'h000);
        checks++; if (pad_out !== exp) $display("FAIL blink_core2: got %h expected %h", pad_out, exp); else passed++;
    endtask

    task automatic test_cfg_err();
        logic [8:0] exp;
        cfg_we = 1'b1; cfg_ch = 4'd9; cfg_mode = 2'b10;
        step();
        cfg_we = 1'b0;
        exp = 9'h00A | (ph(edges) ? 9'h004 : 9'h000);
        checks++; if (cfg_err !== 1'b1) $display("FAIL err_pulse: got %b expected 1", cfg_err); else passed++;
        checks++; if (pad_out !== exp) $display("FAIL err_pad1: got %h expected %h", pad_out, exp); else passed++;
        step();
        exp = 9'h00A | (ph(edges) ? 9'h004 : 9'h000);
        checks++; if (cfg_err !== 1'b0) $display("FAIL err_clear: got %b expected 0", cfg_err); else passed++;
        checks++; if (pad_out !== exp) $display("FAIL err_pad2: got %h expected %h", pad_out, exp); else passed++;
        cfg_we = 1'b1; cfg_ch = 4'd15; cfg_mode = 2'b01;
        step();
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) $display("FAIL err_pulse15: got %b expected 1", cfg_err); else passed++;
        step();
        exp = 9'h00A | (ph(edges) ? 9'h004 : 9'h000);
        checks++; if (pad_out !== exp) $display("FAIL err_pad3: got %h expected %h", pad_out, exp); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp;
        rst_n = 1'b0; boot_done = 1'b1;
        cfg_we = 1'b1; cfg_ch = 4'd5; cfg_mode = 2'b10;
        step();
        edges = 0;
        rst_n = 1'b1; cfg_we = 1'b0; boot_done = 1'b0; core_out = 9'h000;
        checks++; if (pad_out !== SAFE) $display("FAIL rmid_pad: got %h expected %h", pad_out, SAFE); else passed++;
        checks++; if (armed !== 1'b0) $display("FAIL rmid_armed: got %b expected 0", armed); else passed++;
        checks++; if (cfg_err !== 1'b0) $display("FAIL rmid_err: got %b expected 0", cfg_err); else passed++;
        boot_done = 1'b1;
        step();
        boot_done = 1'b0;
        checks++; if (armed !== 1'b1) $display("FAIL rmid_rearm: got %b expected 1", armed); else passed++;
        step();
        checks++; if (pad_out !== 9'h000) $display("FAIL rmid_modes: got %h expected 000", pad_out); else passed++;
        cfg_we = 1'b1; cfg_ch = 4'd2; cfg_mode = 2'b11;
        step();
        cfg_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            exp = ph(edges) ? 9'h004 : 9'h000;
            checks++; if (pad_out !== exp) $display("FAIL rmid_blink: got %h expected %h", pad_out, exp); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_safe();
        test_arming();
        test_force();
        test_blink();
        test_cfg_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
